// File: rtl/mole_field_ctrl.sv
// Mole field controller: per-mole rise/up/fall FSMs on tick enables, plus saturating BCD hit/rise totals.
// All state is registered; totals update on the same edge as the moles (one cycle after the input).
module mole_field_ctrl #(
    parameter int NUM_MOLES  = 8,
    parameter int HW         = 5,
    parameter int MAX_HEIGHT = 20,
    parameter int WW         = 3,
    parameter int WAIT_TICKS = 4,
    parameter int DIGITS     = 4
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      clr_scores,
    input  logic                      rl_tick,
    input  logic                      wait_tick,
    input  logic [NUM_MOLES-1:0]      go,
    input  logic [NUM_MOLES-1:0]      hit,
    output logic [NUM_MOLES*HW-1:0]   mheight,
    output logic [NUM_MOLES-1:0]      hiding,
    output logic [4*DIGITS-1:0]       total_score,
    output logic [4*DIGITS-1:0]       total_rise
);

    localparam int EW = $clog2(NUM_MOLES + 1);
    localparam int CW = $clog2(NUM_MOLES + 10) + 1;

    typedef enum logic [1:0] {HIDDEN, RISE, UP, FALL} state_t;

    state_t         state_q  [NUM_MOLES];
    state_t         state_d  [NUM_MOLES];
    logic [HW-1:0]  height_q [NUM_MOLES];
    logic [HW-1:0]  height_d [NUM_MOLES];
    logic [WW-1:0]  dwell_q  [NUM_MOLES];
    logic [WW-1:0]  dwell_d  [NUM_MOLES];

    logic [NUM_MOLES-1:0] score_ev;
    logic [NUM_MOLES-1:0] rise_ev;
    logic [EW-1:0]        n_score;
    logic [EW-1:0]        n_rise;
    logic [4*DIGITS-1:0]  score_d;
    logic [4*DIGITS-1:0]  rise_d;

    // Ripple a small binary count into a BCD total; any carry out of the top digit saturates.
    function automatic logic [4*DIGITS-1:0] bcd_add(input logic [4*DIGITS-1:0] t,
                                                    input logic [EW-1:0] e);
        logic [CW-1:0]       c;
        logic [CW-1:0]       s;
        logic [4*DIGITS-1:0] r;
        c = CW'(e);
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            s            = CW'(t[4*d +: 4]) + c;
            r[4*d +: 4]  = 4'(s % CW'(10));
            c            = s / CW'(10);
        end
        if (c != '0)
            r = {DIGITS{4'h9}};
        return r;
    endfunction

    always_comb begin
        score_ev = '0;
        rise_ev  = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            state_d[i]  = state_q[i];
            height_d[i] = height_q[i];
            dwell_d[i]  = dwell_q[i];
            if (state_q[i] == HIDDEN) begin
                height_d[i] = '0;
                dwell_d[i]  = '0;
                if (go[i]) begin
                    state_d[i] = RISE;
                    rise_ev[i] = 1'b1;
                end
            end else if (hit[i]) begin
                state_d[i]  = HIDDEN;
                height_d[i] = '0;
                dwell_d[i]  = '0;
                score_ev[i] = 1'b1;
            end else begin
                case (state_q[i])
                    RISE: if (rl_tick) begin
                        height_d[i] = height_q[i] + 1'b1;
                        if (height_q[i] == HW'(MAX_HEIGHT - 1))
                            state_d[i] = UP;
                    end
                    UP: if (wait_tick) begin
                        if (dwell_q[i] == WW'(WAIT_TICKS - 1)) begin
                            state_d[i] = FALL;
                            dwell_d[i] = '0;
                        end else begin
                            dwell_d[i] = dwell_q[i] + 1'b1;
                        end
                    end
                    FALL: if (rl_tick) begin
                        height_d[i] = height_q[i] - 1'b1;
                        if (height_q[i] == HW'(1))
                            state_d[i] = HIDDEN;
                    end
                    default: state_d[i] = HIDDEN;
                endcase
            end
        end

        n_score = '0;
        n_rise  = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            n_score = n_score + EW'(score_ev[i]);
            n_rise  = n_rise  + EW'(rise_ev[i]);
        end

        score_d = clr_scores ? '0 : bcd_add(total_score, n_score);
        rise_d  = clr_scores ? '0 : bcd_add(total_rise, n_rise);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MOLES; i++) begin
                state_q[i]  <= HIDDEN;
                height_q[i] <= '0;
                dwell_q[i]  <= '0;
            end
            total_score <= '0;
            total_rise  <= '0;
        end else begin
            for (int i = 0; i < NUM_MOLES; i++) begin
                state_q[i]  <= state_d[i];
                height_q[i] <= height_d[i];
                dwell_q[i]  <= dwell_d[i];
            end
            total_score <= score_d;
            total_rise  <= rise_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MOLES; i++) begin
            mheight[i*HW +: HW] = height_q[i];
            hiding[i]           = (state_q[i] == HIDDEN);
        end
    end

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Bench for mole_field_ctrl: scripted scenarios plus randomized traffic against a behavioural model.
module tb_mole_field_ctrl;

    localparam int N    = 8;
    localparam int HW   = 5;
    localparam int MAXH = 20;
    localparam int WT   = 4;
    localparam int D    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            clr_scores;
    logic            rl_tick;
    logic            wait_tick;
    logic [N-1:0]    go;
    logic [N-1:0]    hit;
    logic [N*HW-1:0] mheight;
    logic [N-1:0]    hiding;
    logic [4*D-1:0]  total_score;
    logic [4*D-1:0]  total_rise;

    int tests = 0;
    int fails = 0;

    // Model: each mole is either inactive, or active with a height, a direction and a dwell count.
    int m_act [N];
    int m_h   [N];
    int m_dir [N];
    int m_dw  [N];
    int m_sc;
    int m_rs;

    mole_field_ctrl #(
        .NUM_MOLES(N), .HW(HW), .MAX_HEIGHT(MAXH), .WW(3), .WAIT_TICKS(WT), .DIGITS(D)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .clr_scores(clr_scores), .rl_tick(rl_tick),
        .wait_tick(wait_tick), .go(go), .hit(hit), .mheight(mheight), .hiding(hiding),
        .total_score(total_score), .total_rise(total_rise)
    );

    always #5 clk = ~clk;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int x;
        x = v;
        for (int d = 0; d < D; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function void model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_h[i] = 0; m_dir[i] = 0; m_dw[i] = 0;
        end
        m_sc = 0;
        m_rs = 0;
    endfunction

    function void model_step();
        int es;
        int er;
        es = 0;
        er = 0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] == 0) begin
                if (go[i]) begin
                    m_act[i] = 1; m_dir[i] = 1; m_h[i] = 0; m_dw[i] = 0; er++;
                end
            end else if (hit[i]) begin
                m_act[i] = 0; m_h[i] = 0; m_dw[i] = 0; es++;
            end else if (m_dir[i] > 0 && m_h[i] < MAXH) begin
                if (rl_tick) m_h[i]++;
            end else if (m_dir[i] > 0) begin
                if (wait_tick) begin
                    m_dw[i]++;
                    if (m_dw[i] == WT) begin
                        m_dir[i] = -1; m_dw[i] = 0;
                    end
                end
            end else if (rl_tick) begin
                m_h[i]--;
                if (m_h[i] == 0) m_act[i] = 0;
            end
        end
        if (clr_scores) begin
            m_sc = 0;
            m_rs = 0;
        end else begin
            m_sc = (m_sc + es > 9999) ? 9999 : m_sc + es;
            m_rs = (m_rs + er > 9999) ? 9999 : m_rs + er;
        end
    endfunction

    function automatic logic [N*HW-1:0] exp_mh();
        logic [N*HW-1:0] r;
        for (int i = 0; i < N; i++) r[i*HW +: HW] = HW'(m_h[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_hid();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_act[i] == 0);
        return r;
    endfunction

    task automatic idle();
        clr_scores = 1'b0; rl_tick = 1'b0; wait_tick = 1'b0; go = '0; hit = '0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Clear totals and knock every active mole down in one cycle.
    task automatic prep();
        idle();
        clr_scores = 1'b1;
        hit = '1;
        cycle();
        idle();
    endtask

    // Drive the score (sel=0) or rise (sel=1) total up to a target in steps of at most 8.
    task automatic pump(input int target, input int sel);
        int iter;
        int k;
        iter = 0;
        while ((sel == 0 ? m_sc : m_rs) < target) begin
            iter++;
            if (iter > 3000) begin
                tests++; fails++;
                $display("FAIL pump_budget: total=%0d target=%0d", sel == 0 ? m_sc : m_rs, target);
                break;
            end
            k = target - (sel == 0 ? m_sc : m_rs);
            if (k > 8) k = 8;
            idle();
            if (sel == 0) begin
                go = '1; cycle(); idle();
                hit = N'((1 << k) - 1); cycle();
            end else begin
                go = N'((1 << k) - 1); cycle(); idle();
                hit = '1; cycle();
            end
            idle();
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        tests++; if (hiding !== 8'hFF) begin fails++; $display("FAIL rst_hiding: got %h want ff", hiding); end
        tests++; if (mheight !== '0) begin fails++; $display("FAIL rst_mheight: got %h want 0", mheight); end
        tests++; if (total_score !== 16'h0 || total_rise !== 16'h0) begin
            fails++; $display("FAIL rst_totals: got %h/%h want 0/0", total_score, total_rise); end
        reset = 1'b0;
        rl_tick = 1'b1; wait_tick = 1'b1; hit = '1;
        repeat (3) cycle();
        idle();
        tests++; if (hiding !== 8'hFF) begin fails++; $display("FAIL rst_idle_hiding: got %h want ff", hiding); end
        tests++; if (total_score !== 16'h0) begin fails++; $display("FAIL rst_hit_hidden: got %h want 0", total_score); end
    endtask

    task automatic test_reset_mid_rise();
        idle();
        go = 8'h08; cycle(); idle();
        rl_tick = 1'b1; repeat (7) cycle(); idle();
        tests++; if (mheight[3*HW +: HW] !== 5'd7) begin
            fails++; $display("FAIL mid_rise_h3: got %0d want 7", mheight[3*HW +: HW]); end
        tests++; if (total_rise !== 16'h0001) begin fails++; $display("FAIL mid_rise_rise: got %h want 0001", total_rise); end
        reset = 1'b1;
        model_reset();
        #1;
        tests++; if (hiding[3] !== 1'b1) begin fails++; $display("FAIL async_rst_hiding3: got %b want 1", hiding[3]); end
        tests++; if (mheight[3*HW +: HW] !== 5'd0) begin
            fails++; $display("FAIL async_rst_h3: got %0d want 0", mheight[3*HW +: HW]); end
        tests++; if (total_rise !== 16'h0 || total_score !== 16'h0) begin
            fails++; $display("FAIL async_rst_totals: got %h/%h want 0/0", total_score, total_rise); end
        @(posedge clk); #1;
        reset = 1'b0;
        rl_tick = 1'b1; repeat (4) cycle(); idle();
        tests++; if (hiding[3] !== 1'b1) begin fails++; $display("FAIL post_rst_hiding3: got %b want 1", hiding[3]); end
    endtask

    task automatic test_full_cycle();
        idle();
        go = 8'h01; cycle(); idle();
        tests++; if (hiding[0] !== 1'b0) begin fails++; $display("FAIL full_rise_start: hiding0 got %b want 0", hiding[0]); end
        rl_tick = 1'b1; repeat (20) cycle(); idle();
        tests++; if (mheight[HW-1:0] !== 5'd20) begin fails++; $display("FAIL full_top: got %0d want 20", mheight[HW-1:0]); end
        rl_tick = 1'b1; cycle(); idle();
        tests++; if (mheight[HW-1:0] !== 5'd20) begin fails++; $display("FAIL full_clamp: got %0d want 20", mheight[HW-1:0]); end
        wait_tick = 1'b1; repeat (3) cycle(); idle();
        rl_tick = 1'b1; cycle(); idle();
        tests++; if (mheight[HW-1:0] !== 5'd20) begin fails++; $display("FAIL full_dwell_hold: got %0d want 20", mheight[HW-1:0]); end
        wait_tick = 1'b1; cycle(); idle();
        rl_tick = 1'b1; cycle(); idle();
        tests++; if (mheight[HW-1:0] !== 5'd19) begin fails++; $display("FAIL full_fall_start: got %0d want 19", mheight[HW-1:0]); end
        rl_tick = 1'b1; repeat (19) cycle(); idle();
        tests++; if (mheight[HW-1:0] !== 5'd0 || hiding[0] !== 1'b1) begin
            fails++; $display("FAIL full_end: h=%0d hid=%b want 0/1", mheight[HW-1:0], hiding[0]); end
        tests++; if (total_rise !== 16'h0001 || total_score !== 16'h0000) begin
            fails++; $display("FAIL full_totals: got %h/%h want 0000/0001", total_score, total_rise); end
    endtask

    task automatic test_hit_rise();
        prep();
        go = 8'h04; cycle(); idle();
        rl_tick = 1'b1; repeat (11) cycle(); idle();
        tests++; if (mheight[2*HW +: HW] !== 5'd11) begin fails++; $display("FAIL hit_pre_h2: got %0d want 11", mheight[2*HW +: HW]); end
        hit = 8'h04; rl_tick = 1'b1; cycle(); idle();
        tests++; if (mheight[2*HW +: HW] !== 5'd0 || hiding[2] !== 1'b1) begin
            fails++; $display("FAIL hit_knock: h=%0d hid=%b want 0/1", mheight[2*HW +: HW], hiding[2]); end
        tests++; if (total_score !== 16'h0001) begin fails++; $display("FAIL hit_score: got %h want 0001", total_score); end
        hit = 8'h04; cycle(); idle();
        tests++; if (total_score !== 16'h0001) begin fails++; $display("FAIL hit_hidden: got %h want 0001", total_score); end
        go = 8'h02; hit = 8'h02; cycle(); idle();
        tests++; if (hiding[1] !== 1'b0 || total_score !== 16'h0001 || total_rise !== 16'h0002) begin
            fails++; $display("FAIL go_hit_hidden: hid=%b sc=%h rs=%h want 0/0001/0002", hiding[1], total_score, total_rise); end
    endtask

    task automatic test_all_hit();
        prep();
        pump(9, 0);
        tests++; if (total_score !== 16'h0009) begin fails++; $display("FAIL allhit_pre: got %h want 0009", total_score); end
        go = '1; cycle(); idle();
        rl_tick = 1'b1; repeat (20) cycle(); idle();
        tests++; if (hiding !== 8'h00 || mheight !== exp_mh()) begin
            fails++; $display("FAIL allhit_up: hid=%h mh=%h want 00/%h", hiding, mheight, exp_mh()); end
        hit = '1; cycle(); idle();
        tests++; if (total_score !== 16'h0017) begin fails++; $display("FAIL allhit_bcd: got %h want 0017", total_score); end
    endtask

    task automatic test_saturation();
        prep();
        pump(9998, 0);
        tests++; if (total_score !== 16'h9998) begin fails++; $display("FAIL sat_pre: got %h want 9998", total_score); end
        go = '1; cycle(); idle();
        hit = 8'h07; cycle(); idle();
        tests++; if (total_score !== 16'h9999) begin fails++; $display("FAIL sat_hold: got %h want 9999", total_score); end
        go = '1; cycle(); idle();
        hit = 8'h01; cycle(); idle();
        tests++; if (total_score !== 16'h9999) begin fails++; $display("FAIL sat_stay: got %h want 9999", total_score); end
    endtask

    task automatic test_clear();
        prep();
        pump(42, 1);
        tests++; if (total_rise !== 16'h0042) begin fails++; $display("FAIL clr_pre: got %h want 0042", total_rise); end
        go = 8'h01; clr_scores = 1'b1; cycle(); idle();
        tests++; if (total_rise !== 16'h0000 || total_score !== 16'h0000) begin
            fails++; $display("FAIL clr_totals: got %h/%h want 0000/0000", total_score, total_rise); end
        tests++; if (hiding[0] !== 1'b0) begin fails++; $display("FAIL clr_mole0: hiding0 got %b want 0", hiding[0]); end
    endtask

    task automatic test_random();
        prep();
        for (int c = 0; c < 3000; c++) begin
            go        = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            hit       = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            rl_tick   = $urandom_range(0, 1) == 1;
            wait_tick = $urandom_range(0, 2) == 0;
            clr_scores = $urandom_range(0, 199) == 0;
            cycle();
            tests++; if (mheight !== exp_mh()) begin fails++; $display("FAIL rnd_mheight c=%0d: got %h want %h", c, mheight, exp_mh()); end
            tests++; if (hiding !== exp_hid()) begin fails++; $display("FAIL rnd_hiding c=%0d: got %h want %h", c, hiding, exp_hid()); end
            tests++; if (total_score !== to_bcd(m_sc)) begin fails++; $display("FAIL rnd_score c=%0d: got %h want %h", c, total_score, to_bcd(m_sc)); end
            tests++; if (total_rise !== to_bcd(m_rs)) begin fails++; $display("FAIL rnd_rise c=%0d: got %h want %h", c, total_rise, to_bcd(m_rs)); end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        test_reset();
        test_reset_mid_rise();
        test_full_cycle();
        test_hit_rise();
        test_all_hit();
        test_saturation();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mole_field_ctrl.md
Name: mole_field_ctrl

Overview:
- Parametrised, fully synchronous controller for a field of NUM_MOLES moles.
- Each mole runs its own rise/up/fall FSM with a height and a dwell counter. Hits and rises are tallied into two saturating BCD totals.
- Replaces gated/derived clocks with single-cycle tick enables on one clock.
- Sits between the game sequencer (go, hit) and the display/score path (mheight, totals).

Parameters:
- NUM_MOLES, 8, number of mole channels.
- HW, 5, height field width in bits.
- MAX_HEIGHT, 20, fully-up height. Must be in 1..2^HW-1.
- WW, 3, dwell counter width in bits.
- WAIT_TICKS, 4, wait_tick pulses spent fully up. Must be in 1..2^WW-1.
- DIGITS, 4, BCD digits per total.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears everything.
- clr_scores  in  1  synchronous clear of both totals; moles are unaffected.
- rl_tick  in  1  one-cycle enable that advances height by one step.
- wait_tick  in  1  one-cycle enable that advances the dwell counter.
- go  in  NUM_MOLES  per-mole start request; level sampled each cycle.
- hit  in  NUM_MOLES  per-mole hit strobe; level sampled each cycle.
- mheight  out  NUM_MOLES*HW  heights; mole i occupies bits [i*HW +: HW].
- hiding  out  NUM_MOLES  1 when the mole is in HIDDEN.
- total_score  out  4*DIGITS  BCD hit total; digit 0 (ones) at bits [3:0].
- total_rise  out  4*DIGITS  BCD rise total; same digit layout.

Behaviour:
- Reset (async): every mole enters HIDDEN with height 0 and dwell 0. hiding = all 1s, mheight = 0, both totals = 0.
- Per-mole FSM: HIDDEN, RISE, UP, FALL. All transitions and outputs are registered.
  - HIDDEN: height held at 0, dwell held at 0. If go=1, next state is RISE and a rise event is generated this cycle.
  - RISE: on rl_tick, height increments. On the rl_tick where height == MAX_HEIGHT-1, height becomes MAX_HEIGHT and state becomes UP.
  - UP: on wait_tick, dwell increments. On the wait_tick where dwell == WAIT_TICKS-1, state becomes FALL and dwell returns to 0.
  - FALL: on rl_tick, height decrements. On the rl_tick where height == 1, height becomes 0 and state becomes HIDDEN.
- Hit handling:
  - hit=1 in RISE, UP or FALL: generates a score event. Next cycle the mole is HIDDEN with height 0 and dwell 0.
  - Hit has priority over any tick in the same cycle.
  - hit in HIDDEN is ignored: no score event.
  - go outside HIDDEN is ignored.
  - go and hit together in HIDDEN: go is taken and a rise event is generated; the hit is ignored.
  - A held go re-triggers a rise on the cycle after the mole re-enters HIDDEN. This is legal.
- Totals:
  - Per cycle, e_s = number of score events and e_r = number of rise events, each 0..NUM_MOLES.
  - Each total becomes total + e (BCD addition with ripple carry over DIGITS digits) on the same edge that changes mole state. Latency is one cycle from the triggering input.
  - Saturation: if the true sum exceeds 10^DIGITS-1, the total holds all-9s. It never wraps.
  - clr_scores=1 forces both totals to 0 and discards that cycle's events.
- Ticks only advance moles in the relevant state. Ticks arriving while HIDDEN have no effect.
- Outputs never show a height outside 0..MAX_HEIGHT. Every BCD digit is always in 0..9.

Test Plan:
- Reset mid-RISE, with mole 3 at height 7 → immediately hiding[3]=1, mheight slice 3 = 0, totals = 0; after release, mole 3 stays HIDDEN until go.
- go[0] pulse, then 20 rl_ticks, 4 wait_ticks, 20 rl_ticks → height 0→20, UP held through 3 wait_ticks, then 20→0, hiding[0]=1; total_rise=0x0001, total_score=0.
- hit[2] at height 11 in RISE, together with rl_tick → next cycle height 0, hiding[2]=1; total_score=0x0001; a further hit[2] in HIDDEN leaves the score at 0x0001.
- All 8 moles up; hit=8'hFF for one cycle with total_score=0x0009 → total_score=0x0017 (BCD 17) next cycle.
- total_score=0x9998, then 3 simultaneous hits → 0x9999, saturated; a further hit leaves it at 0x9999.
- clr_scores asserted in the same cycle as go=8'h01 with total_rise=0x0042 → total_rise=0x0000 and the rise is not counted; mole 0 still enters RISE.
